// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: direct-mapped table of 2-bit saturating counters
// indexed by fetch PC.
// It supplies a taken prediction to fetch and checks each resolving branch
// against the prediction it carried down the pipeline.
// When the two disagree, it issues a registered PC redirect and a two-cycle
// flush of the younger stages.
//
// Optional feature macro: BRANCH_PREDICT_STATS_EN
//   defined   -> branch_cnt / mispred_cnt are saturating 16-bit event counters
//   undefined -> both count ports are tied to 16'h0000; the port list is the same
//                in both builds.
//
// Handshake: redirect_valid is a single-cycle registered pulse.
// While it is high, redirect_pc holds the corrected fetch address.
// Fetch must accept it unconditionally; there is no ready back-pressure.
// flush is high for exactly two cycles, starting with the redirect pulse.
module branch_predict_ctrl #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_zero,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic [31:0] ex_pc_plus4,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispred_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH1 = 2'd1,
        ST_FLUSH2 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q [DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             resolve;
    logic             taken;
    logic             mispredict;
    logic             tbl_upd;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic             unused_pc_bits;

    // Only the word-index bits of the PCs select a table entry.
    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0],
                              ex_pc[31:IDX_W+2], ex_pc[1:0]};

    // A resolve is only honoured in RUN.
    // Anything presented while flushing belongs to a squashed instruction.
    assign resolve    = ex_valid & ~stall & (state_q == ST_RUN);
    assign taken      = ex_branch & ex_zero;
    assign mispredict = resolve & (ex_pred_taken != taken);
    assign tbl_upd    = resolve & ex_branch;

    // Lookup reads the stored value, so a same-cycle update is seen next cycle.
    assign pred_taken = cnt_q[if_idx][1];

    // Next-state and registered-output logic for the flush sequencer.
    always_comb begin
        state_d          = state_q;
        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = mispredict | (state_q == ST_FLUSH1);
        if (mispredict) begin
            redirect_pc_d = taken ? ex_target : ex_pc_plus4;
        end
        case (state_q)
            ST_RUN:    if (mispredict) state_d = ST_FLUSH1;
            ST_FLUSH1: state_d = ST_FLUSH2;
            ST_FLUSH2: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // State and redirect/flush registers; the flush states ignore stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
            flush_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;

    // Counter table: reset to weakly not-taken, saturating update per branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= 2'b01;
            end
        end else if (tbl_upd) begin
            if (taken && cnt_q[ex_idx] != 2'b11) begin
                cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'b01;
            end else if (!taken && cnt_q[ex_idx] != 2'b00) begin
                cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'b01;
            end
        end
    end

`ifdef BRANCH_PREDICT_STATS_EN
    logic [15:0] branch_cnt_q;
    logic [15:0] mispred_cnt_q;

    // Saturating event counters for resolved branches and mispredicts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q  <= 16'h0;
            mispred_cnt_q <= 16'h0;
        end else begin
            if (tbl_upd && branch_cnt_q != 16'hFFFF) begin
                branch_cnt_q <= branch_cnt_q + 16'd1;
            end
            if (mispredict && mispred_cnt_q != 16'hFFFF) begin
                mispred_cnt_q <= mispred_cnt_q + 16'd1;
            end
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`else
    assign branch_cnt  = 16'h0000;
    assign mispred_cnt = 16'h0000;
`endif

endmodule
